// File: rtl/glitch_sequencer_if.sv
// Control, configuration and status bundle for the glitch sequencer.
interface glitch_sequencer_if #(
  parameter int unsigned DLY_W = 24,
  parameter int unsigned WID_W = 16,
  parameter int unsigned REP_W = 8
) ();

  logic             ARM;
  logic             ABORT;
  logic             TRIG;
  logic [DLY_W-1:0] DELAY;
  logic [WID_W-1:0] WIDTH;
  logic [DLY_W-1:0] GAP;
  logic [REP_W-1:0] REPEAT;
  logic             GLITCH;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  // Controller side: drives requests and configuration, observes status.
  modport master (
    output ARM, ABORT, TRIG, DELAY, WIDTH, GAP, REPEAT,
    input  GLITCH, BUSY, DONE, ERR
  );

  // Sequencer side.
  modport slave (
    input  ARM, ABORT, TRIG, DELAY, WIDTH, GAP, REPEAT,
    output GLITCH, BUSY, DONE, ERR
  );

endinterface

// File: rtl/glitch_sequencer.sv
// Trigger-synchronised glitch pulse generator: after an armed trigger edge,
// waits DELAY cycles, then emits REPEAT+1 pulses of WIDTH cycles separated
// by max(GAP,1) low cycles.
module glitch_sequencer #(
  parameter int unsigned DLY_W = 24,
  parameter int unsigned WID_W = 16,
  parameter int unsigned REP_W = 8
) (
  input logic               CLK,
  input logic               RST,
  glitch_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (DLY_W > WID_W) ? DLY_W : WID_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sync_q, sync_d;     // [0],[1] synchronizer, [2] history
  logic [CNT_W-1:0] cnt_q, cnt_d;       // down-counter for DELAY/PULSE/GAP
  logic [REP_W-1:0] pcnt_q, pcnt_d;     // pulses already completed
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [WID_W-1:0] wid_q, wid_d;
  logic [DLY_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             glitch_q, glitch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             trig_edge_c;

  assign trig_edge_c = sync_q[1] & ~sync_q[2];

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[1:0], bus.TRIG};
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    gap_d   = gap_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.ABORT) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ARM) begin
            if (bus.WIDTH == '0) begin
              err_d = 1'b1;
            end else begin
              dly_d   = bus.DELAY;
              wid_d   = bus.WIDTH;
              gap_d   = bus.GAP;
              rep_d   = bus.REPEAT;
              pcnt_d  = '0;
              state_d = ST_ARMED;
            end
          end
        end

        ST_ARMED: begin
          if (trig_edge_c) begin
            if (dly_q == '0) begin
              state_d = ST_PULSE;
              cnt_d   = CNT_W'(wid_q);
            end else begin
              state_d = ST_DELAY;
              cnt_d   = CNT_W'(dly_q);
            end
          end
        end

        ST_DELAY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_PULSE;
            cnt_d   = CNT_W'(wid_q);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_PULSE: begin
          if (cnt_q == CNT_W'(1)) begin
            if (pcnt_q == rep_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              cnt_d   = '0;
              pcnt_d  = '0;
            end else begin
              state_d = ST_GAP;
              pcnt_d  = pcnt_q + REP_W'(1);
              cnt_d   = (gap_q == '0) ? CNT_W'(1) : CNT_W'(gap_q);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_PULSE;
            cnt_d   = CNT_W'(wid_q);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pcnt_d  = '0;
        end
      endcase
    end

    // Outputs follow the state being entered so GLITCH is a plain flop.
    glitch_d = (state_d == ST_PULSE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counter, config and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      sync_q   <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      dly_q    <= '0;
      wid_q    <= '0;
      gap_q    <= '0;
      rep_q    <= '0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      dly_q    <= dly_d;
      wid_q    <= wid_d;
      gap_q    <= gap_d;
      rep_q    <= rep_d;
      glitch_q <= glitch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.GLITCH = glitch_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.ERR    = err_q;

endmodule
